mem_1rw_mask_init: RTL and testbench
====================================

# mem_1rw_mask_init

Parametrised single-port (1RW) synchronous memory. It generalises the fixed 48x64 unmasked macro with configurable depth and width, per-granule write masking, and a configurable read pipeline with a valid strobe. It can also zero-initialise itself after reset under a hardware sequencer. It sits in the same memory-lowering layer as the other 1RW macros and serves as the generic replacement wherever a mask, deeper read pipelining or known post-reset contents are required.

## Interface

Parameters:
- DEPTH, 48: number of words; any value >= 2.
- WIDTH, 64: word width in bits.
- MASK_GRAN, 8: bits per write-mask granule. WIDTH % MASK_GRAN != 0 is an elaboration error. MASK_GRAN == WIDTH gives a 1-bit mask.
- READ_LATENCY, 1: cycles from accepted read to data; legal range 1..4, anything else is an elaboration error.
- INIT_ON_RESET, 1: 1 = zero every word after reset; 0 = no initialisation, contents undefined.
- Derived: AW = max(1, clog2(DEPTH)); MW = WIDTH / MASK_GRAN.

Ports:
- RW0_clk  input  1  clock; all logic is rising-edge.
- RW0_rst_n  input  1  asynchronous, active-low reset.
- RW0_addr  input  AW  word address.
- RW0_en  input  1  request strobe.
- RW0_wmode  input  1  1 = write, 0 = read; sampled with RW0_en.
- RW0_wmask  input  MW  per-granule write enable; bit i covers wdata[i*MASK_GRAN +: MASK_GRAN].
- RW0_wdata  input  WIDTH  write data.
- RW0_rdata  output  WIDTH  read data.
- RW0_rvalid  output  1  one-cycle pulse marking RW0_rdata valid.
- RW0_ready  output  1  1 = requests accepted; 0 during initialisation.

## Operation

- **Reset.** Asserting RW0_rst_n low has immediate effect, independent of the clock:
  - RW0_rdata = 0, RW0_rvalid = 0 and all pipeline valid bits = 0.
  - Init counter = 0.
  - FSM goes to INIT if INIT_ON_RESET = 1, otherwise to RUN.
  - RW0_ready = 0 in INIT, 1 in RUN.
  - Storage contents are not reset.
- **INIT state.**
  - On each clock edge, word[cnt] is written to 0 and cnt increments.
  - On the edge that writes word[DEPTH-1], the FSM moves to RUN.
  - Requests arriving during INIT are ignored and dropped, not queued.
- **RUN state.** A request is accepted when RW0_en = 1 and RW0_ready = 1.
  - **Write** (wmode = 1): for each granule with wmask[i] = 1, word[addr] takes wdata for that granule. Other granules keep their value. wmask = 0 is a legal no-op. A write never asserts rvalid.
  - **Read** (wmode = 0): word[addr] is sampled at the accepting edge and shifted through a pipeline of READ_LATENCY stages.
    - The last stage drives RW0_rdata and RW0_rvalid.
    - RW0_rdata holds its last valid value while rvalid = 0.
- **Out-of-range address** (addr >= DEPTH, possible when DEPTH is not a power of 2):
  - Writes are dropped.
  - Reads return all-zero data with a normal rvalid pulse.
- **Consecutive accesses.** One access per cycle at full rate, with no bubbles. A read on the cycle after a write to the same address returns the newly written data, including the mask merge.
- **Reset during INIT.** Initialisation restarts from word 0.
- **Reset during RUN.** Reads still in the pipeline are lost and produce no rvalid.

## Timing

- **Read latency.** A read accepted at edge N produces rvalid = 1 and valid rdata in the cycle following edge N + READ_LATENCY - 1. With READ_LATENCY = 1, data is visible after the same edge that accepted the read, matching the legacy macro.
- **Throughput.** Back-to-back reads on edges N, N+1, ... produce rvalid on consecutive cycles in request order.
- **INIT duration.** INIT lasts exactly DEPTH clock edges after reset is released. The first rising edge after RW0_rst_n goes high writes word 0. RW0_ready goes to 1 after edge DEPTH and is registered, with no combinational path from inputs.
- **Non-initialising configuration.** With INIT_ON_RESET = 0, RW0_ready = 1 throughout and from reset.
- **Outputs.** All outputs are registered; there is no combinational path from any input to any output.

## Test plan

- **Init then read.** DEPTH = 48, INIT_ON_RESET = 1. Release reset and count edges until ready.
  - Ready must rise after exactly 48 edges.
  - Reading addresses 0..47 returns 0 with one rvalid per read.
- **Masked write.** WIDTH = 64, MASK_GRAN = 8. Write 0xFFFF_FFFF_FFFF_FFFF to address 5 with wmask = 0xFF, then write 0x1122_3344_5566_7788 with wmask = 0x0F.
  - Reading address 5 returns 0xFFFF_FFFF_5566_7788.
- **Latency sweep.** Run READ_LATENCY = 1..4 with 10 back-to-back reads of distinct pre-written values.
  - The first rvalid appears at exactly READ_LATENCY cycles, followed by 10 consecutive rvalid pulses.
  - Data arrives in order.
- **Out-of-range and dropped requests.**
  - DEPTH = 48: a write to address 50, then a read of address 50, returns 0 with rvalid.
  - Requests issued during INIT leave the memory at 0 and produce no rvalid.
- **Reset mid-operation.** Issue 3 reads with READ_LATENCY = 3, then pull RW0_rst_n low after the second edge.
  - rvalid = 0 and rdata = 0 immediately, and none of the 3 reads produces rvalid.
  - After reset release, INIT restarts from word 0, lasting 48 edges.
- **Write-then-read.** Write 0xA5 to address 7, then read address 7 on the next cycle.
  - The read returns 0xA5 with no intervening rvalid from the write.

Source files
------------

// File: rtl/mem_1rw_mask_init.sv
// Parametrised 1RW memory: per-granule write mask, configurable read latency
// and an optional zero-fill sequencer that runs after reset.
module mem_1rw_mask_init #(
   parameter int DEPTH         = 48,
   parameter int WIDTH         = 64,
   parameter int MASK_GRAN     = 8,
   parameter int READ_LATENCY  = 1,
   parameter int INIT_ON_RESET = 1,
   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   localparam int MW = WIDTH / MASK_GRAN
) (
   input  logic             RW0_clk,
   input  logic             RW0_rst_n,
   input  logic [AW-1:0]    RW0_addr,
   input  logic             RW0_en,
   input  logic             RW0_wmode,
   input  logic [MW-1:0]    RW0_wmask,
   input  logic [WIDTH-1:0] RW0_wdata,
   output logic [WIDTH-1:0] RW0_rdata,
   output logic             RW0_rvalid,
   output logic             RW0_ready
);

   if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
      $error("WIDTH must be a multiple of MASK_GRAN");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
      $error("READ_LATENCY must be in 1..4");
   end

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   state_t           state;
   logic [AW-1:0]    cnt;
   logic             ready_q;
   logic             acc;
   logic             in_range;
   logic             wr_acc;
   logic             rd_acc;
   logic [WIDTH-1:0] rd_word;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [WIDTH-1:0]        pd [READ_LATENCY];
   logic [READ_LATENCY-1:0] pv;

   assign acc      = RW0_en & ready_q;
   assign in_range = {1'b0, RW0_addr} < DEPTH_W;
   assign wr_acc   = acc & RW0_wmode & in_range;
   assign rd_acc   = acc & ~RW0_wmode;
   assign rd_word  = in_range ? mem[RW0_addr] : '0;

   always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
         state   <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
         cnt     <= '0;
         ready_q <= (INIT_ON_RESET == 0);
      end else if (state == ST_INIT) begin
         cnt <= cnt + 1'b1;
         if (cnt == LAST) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge RW0_clk) begin
      if (state == ST_INIT) begin
         mem[cnt] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < MW; i++) begin
            if (RW0_wmask[i]) begin
               mem[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <=
                  RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

   // Data stages load only with valid data, so the last one holds its value.
   always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
         pv <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pd[i] <= '0;
         end
      end else begin
         pv[0] <= rd_acc;
         if (rd_acc) begin
            pd[0] <= rd_word;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            pv[i] <= pv[i-1];
            if (pv[i-1]) begin
               pd[i] <= pd[i-1];
            end
         end
      end
   end

   assign RW0_rdata  = pd[READ_LATENCY-1];
   assign RW0_rvalid = pv[READ_LATENCY-1];
   assign RW0_ready  = ready_q;

endmodule

// File: tb/tb_mem_1rw_mask_init.sv
// Bench for mem_1rw_mask_init: four instances (READ_LATENCY 1..4) share one
// stimulus stream and are checked against an array model of the memory.
module tb_mem_1rw_mask_init;

   localparam int DEPTH = 48;
   localparam int NL    = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        wmode;
   logic [5:0]  addr;
   logic [7:0]  wmask;
   logic [63:0] wdata;

   logic [63:0] rdata_a  [1:NL];
   logic        rvalid_a [1:NL];
   logic        ready_a  [1:NL];

   always #5 clk = ~clk;

   for (genvar g = 1; g <= NL; g++) begin : g_dut
      mem_1rw_mask_init #(
         .DEPTH(DEPTH),
         .WIDTH(64),
         .MASK_GRAN(8),
         .READ_LATENCY(g),
         .INIT_ON_RESET(1)
      ) u_dut (
         .RW0_clk(clk),
         .RW0_rst_n(rst_n),
         .RW0_addr(addr),
         .RW0_en(en),
         .RW0_wmode(wmode),
         .RW0_wmask(wmask),
         .RW0_wdata(wdata),
         .RW0_rdata(rdata_a[g]),
         .RW0_rvalid(rvalid_a[g]),
         .RW0_ready(ready_a[g])
      );
   end

   int          passed = 0;
   int          failed = 0;
   int          total  = 0;
   logic [63:0] model   [DEPTH];
   logic [5:0]  rd_addr [16];
   logic [5:0]  wa      [10];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      en    = 1'b0;
      wmode = 1'b0;
      wmask = '0;
   endtask

   function automatic logic any_rv();
      logic r;
      r = 1'b0;
      for (int l = 1; l <= NL; l++) r |= rvalid_a[l];
      return r;
   endfunction

   task automatic wr(input logic [5:0] a, input logic [63:0] d,
                     input logic [7:0] m);
      logic [63:0] bm;
      en    = 1'b1;
      wmode = 1'b1;
      addr  = a;
      wdata = d;
      wmask = m;
      cycle();
      idle();
      chk("wr_no_rvalid", 64'(any_rv()), 64'd0);
      if (a < DEPTH) begin
         bm = '0;
         for (int i = 0; i < 8; i++)
            if (m[i]) bm |= 64'hFF << (8 * i);
         model[a] = (model[a] & ~bm) | (d & bm);
      end
   endtask

   // Read k issued before edge k must show up after edge k+L-1 on instance L.
   task automatic burst(input int n);
      logic [63:0] expq [16];
      int          j;
      logic        ev;
      for (int i = 0; i < n; i++)
         expq[i] = (rd_addr[i] < DEPTH) ? model[rd_addr[i]] : 64'd0;
      for (int k = 0; k < n + NL; k++) begin
         if (k < n) begin
            en    = 1'b1;
            wmode = 1'b0;
            addr  = rd_addr[k];
         end else begin
            idle();
         end
         cycle();
         for (int l = 1; l <= NL; l++) begin
            j  = k - (l - 1);
            ev = (j >= 0 && j < n);
            chk($sformatf("rvalid_L%0d_k%0d", l, k),
                64'(rvalid_a[l]), 64'(ev));
            if (ev)
               chk($sformatf("rdata_L%0d_a%0d", l, rd_addr[j]),
                   rdata_a[l], expq[j]);
         end
      end
      idle();
   endtask

   // Requests are thrown at the DUT during INIT; none may be accepted.
   task automatic wait_init(input string tag);
      int   e;
      logic spur;
      e    = 0;
      spur = 1'b0;
      while (!ready_a[1] && e < 100) begin
         en    = 1'b1;
         wmode = 1'($urandom_range(0, 1));
         addr  = 6'($urandom_range(0, DEPTH - 1));
         wdata = {$urandom, $urandom};
         wmask = 8'($urandom);
         cycle();
         e++;
         if (any_rv()) spur = 1'b1;
      end
      idle();
      chk({tag, "_edges"}, 64'(e), 64'd48);
      chk({tag, "_no_rvalid"}, 64'(spur), 64'd0);
      for (int l = 1; l <= NL; l++)
         chk($sformatf("%s_ready_L%0d", tag, l), 64'(ready_a[l]), 64'd1);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   initial begin
      logic spur;
      rst_n = 1'b0;
      addr  = '0;
      wdata = '0;
      idle();
      repeat (2) cycle();
      for (int l = 1; l <= NL; l++) begin
         chk($sformatf("rst_ready_L%0d", l), 64'(ready_a[l]), 64'd0);
         chk($sformatf("rst_rvalid_L%0d", l), 64'(rvalid_a[l]), 64'd0);
         chk($sformatf("rst_rdata_L%0d", l), rdata_a[l], 64'd0);
      end

      rst_n = 1'b1;
      wait_init("init1");

      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 16; i++) rd_addr[i] = 6'(b * 16 + i);
         burst(16);
      end

      wr(6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      wr(6'd5, 64'h1122_3344_5566_7788, 8'h0F);
      rd_addr[0] = 6'd5;
      burst(1);

      for (int i = 0; i < 10; i++) begin
         wa[i] = 6'(i * 4 + 2);
         wr(wa[i], {$urandom, $urandom}, 8'hFF);
      end
      for (int i = 0; i < 4; i++)
         wr(wa[$urandom_range(0, 9)], {$urandom, $urandom}, 8'($urandom));
      for (int i = 0; i < 10; i++) rd_addr[i] = wa[9 - i];
      burst(10);

      wr(6'd50, {$urandom, $urandom} | 64'h1, 8'hFF);
      rd_addr[0] = 6'd50;
      rd_addr[1] = 6'd63;
      rd_addr[2] = 6'd47;
      rd_addr[3] = 6'd2;
      burst(4);

      wr(6'd7, 64'hA5, 8'hFF);
      rd_addr[0] = 6'd7;
      burst(1);

      en    = 1'b1;
      wmode = 1'b0;
      addr  = 6'd2;
      cycle();
      addr  = 6'd7;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int l = 1; l <= NL; l++) begin
         chk($sformatf("midrst_rvalid_L%0d", l), 64'(rvalid_a[l]), 64'd0);
         chk($sformatf("midrst_rdata_L%0d", l), rdata_a[l], 64'd0);
      end
      addr = 6'd5;
      @(negedge clk);
      idle();
      spur = 1'b0;
      repeat (4) begin
         cycle();
         if (any_rv()) spur = 1'b1;
      end
      chk("midrst_lost_reads", 64'(spur), 64'd0);
      rst_n = 1'b1;
      wait_init("init2");

      rd_addr[0] = 6'd0;
      rd_addr[1] = 6'd2;
      rd_addr[2] = 6'd5;
      rd_addr[3] = 6'd7;
      rd_addr[4] = 6'd47;
      burst(5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
